// File: rtl/exc_pkg.sv
// Shared exception definitions: vector classes, FSM state encoding and handler table defaults.
// Also used by the ID-stage vector logic.
package exc_pkg;

    localparam logic [4:0]  VEC_NONE     = 5'b00000;
    localparam logic [4:0]  VEC_IRQ      = 5'b00001;
    localparam logic [4:0]  VEC_PRIV     = 5'b11000;
    localparam logic [4:0]  VEC_NODEF    = 5'b11001;
    localparam logic [1:0]  VEC_TRAP_PFX = 2'b10;

    localparam logic [31:0] VEC_BASE_DEF        = 32'h0000_0100;
    localparam int unsigned VEC_STRIDE_LOG2_DEF = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FLUSH = 3'd1,
        S_SAVE  = 3'd2,
        S_JUMP  = 3'd3,
        S_RET   = 3'd4
    } exc_state_t;

    // Traps commit their instruction and return past it.
    function automatic logic is_trap(input logic [4:0] v);
        return v[4:3] == VEC_TRAP_PFX;
    endfunction

endpackage

// File: rtl/exc_prio.sv
// Accept-priority selection for the commit stage: explicit vector, then rfe, then enabled interrupt.
module exc_prio
    import exc_pkg::*;
(
    input  logic       idle,
    input  logic       valid_wb,
    input  logic [4:0] vector_wb,
    input  logic       rfe_wb,
    input  logic       ext_irq,
    input  logic       ie,
    input  logic       s_u,
    output logic       accept,
    output logic       accept_rfe,
    output logic [4:0] accept_vec,
    output logic       kill
);

    always_comb begin
        accept     = 1'b0;
        accept_rfe = 1'b0;
        accept_vec = VEC_NONE;
        kill       = 1'b0;
        if (idle && valid_wb) begin
            if (vector_wb != VEC_NONE) begin
                accept     = 1'b1;
                accept_vec = vector_wb;
                kill       = !is_trap(vector_wb);
            end else if (rfe_wb) begin
                // rfe from user mode is a privilege violation, never a return
                accept     = 1'b1;
                accept_rfe = !s_u;
                accept_vec = s_u ? VEC_PRIV : VEC_NONE;
                kill       = 1'b1;
            end else if (ext_irq && ie) begin
                accept     = 1'b1;
                accept_vec = VEC_IRQ;
                kill       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Exception / rfe sequencer: flushes the pipeline, saves status and redirects fetch
// to the handler table or back to the saved PC.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_BASE        = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE_LOG2 = VEC_STRIDE_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_wb,
    input  logic [4:0]  vector_wb,
    input  logic [31:0] pc_wb,
    input  logic        rfe_wb,
    input  logic        ext_irq,
    output logic        kill_wb,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        s_u,
    output logic        ie,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        busy
);

    exc_state_t  state, state_nx;
    logic        accept, accept_rfe, prio_kill;
    logic [4:0]  accept_vec;
    logic [4:0]  vec_q;
    logic [31:0] pc_q;
    logic        rfe_q;
    logic [1:0]  saved_sts;
    logic [31:0] vec_target;

    exc_prio u_prio (
        .idle       (state == S_IDLE),
        .valid_wb   (valid_wb),
        .vector_wb  (vector_wb),
        .rfe_wb     (rfe_wb),
        .ext_irq    (ext_irq),
        .ie         (ie),
        .s_u        (s_u),
        .accept     (accept),
        .accept_rfe (accept_rfe),
        .accept_vec (accept_vec),
        .kill       (prio_kill)
    );

    assign kill_wb    = rst_n && prio_kill;
    assign busy       = (state != S_IDLE);
    assign vec_target = VEC_BASE + (32'(vec_q) << VEC_STRIDE_LOG2);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_FLUSH;
            S_FLUSH: begin
                flush    = 1'b1;
                state_nx = rfe_q ? S_RET : S_SAVE;
            end
            S_SAVE:  state_nx = S_JUMP;
            S_JUMP: begin
                redirect    = 1'b1;
                redirect_pc = vec_target;
                state_nx    = S_IDLE;
            end
            S_RET: begin
                redirect    = 1'b1;
                redirect_pc = epc;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q     <= '0;
            pc_q      <= '0;
            rfe_q     <= 1'b0;
            epc       <= '0;
            cause     <= '0;
            s_u       <= 1'b0;
            ie        <= 1'b0;
            saved_sts <= '0;
        end else begin
            if (state == S_IDLE && accept) begin
                vec_q <= accept_vec;
                pc_q  <= pc_wb;
                rfe_q <= accept_rfe;
            end
            if (state == S_SAVE) begin
                epc       <= is_trap(vec_q) ? pc_q + 32'd4 : pc_q;
                cause     <= vec_q;
                saved_sts <= {s_u, ie};
                s_u       <= 1'b0;
                ie        <= 1'b0;
            end
            if (state == S_RET) begin
                {s_u, ie} <= saved_sts;
            end
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed-vector bench for exception_ctrl with hand-computed expectations.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_wb;
    logic [4:0]  vector_wb;
    logic [31:0] pc_wb;
    logic        rfe_wb;
    logic        ext_irq;
    logic        kill_wb, flush, redirect, s_u, ie, busy;
    logic [31:0] redirect_pc, epc;
    logic [4:0]  cause;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    exception_ctrl #(
        .VEC_BASE        (32'h0000_0100),
        .VEC_STRIDE_LOG2 (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_wb    (valid_wb),
        .vector_wb   (vector_wb),
        .pc_wb       (pc_wb),
        .rfe_wb      (rfe_wb),
        .ext_irq     (ext_irq),
        .kill_wb     (kill_wb),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .s_u         (s_u),
        .ie          (ie),
        .epc         (epc),
        .cause       (cause),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_wb  = 1'b0;
        vector_wb = 5'b0;
        rfe_wb    = 1'b0;
        ext_irq   = 1'b0;
    endtask

    // Full exception sequence from the accept cycle through the return to IDLE.
    task automatic run_exc(input logic [4:0] vec, input logic rfe, input logic irq,
                           input logic [31:0] pc, input logic exp_kill,
                           input logic [4:0] exp_cause, input logic [31:0] exp_epc,
                           input logic [31:0] exp_rpc, input logic exp_su_prev);
        valid_wb = 1'b1; vector_wb = vec; rfe_wb = rfe; ext_irq = irq; pc_wb = pc;
        #1;
        chk("accept_kill", kill_wb, exp_kill);
        chk("accept_flush", flush, 0);
        step();
        // junk while busy must be ignored
        valid_wb = 1'b1; vector_wb = 5'b11010; rfe_wb = 1'b1; ext_irq = 1'b1; pc_wb = 32'hDEAD_0000;
        #1;
        chk("flush_flush", flush, 1);
        chk("flush_busy", busy, 1);
        chk("flush_redirect", redirect, 0);
        chk("busy_kill", kill_wb, 0);
        step();
        idle_inputs();
        chk("save_flush", flush, 0);
        chk("save_su_prev", s_u, exp_su_prev);
        chk("save_redirect", redirect, 0);
        step();
        chk("jump_redirect", redirect, 1);
        chk("jump_rpc", redirect_pc, exp_rpc);
        chk("jump_epc", epc, exp_epc);
        chk("jump_cause", cause, 32'(exp_cause));
        chk("jump_su", s_u, 0);
        chk("jump_ie", ie, 0);
        step();
        chk("post_busy", busy, 0);
        chk("post_redirect", redirect, 0);
        chk("post_rpc", redirect_pc, 0);
    endtask

    task automatic run_rfe(input logic [31:0] exp_rpc, input logic exp_su, input logic exp_ie);
        valid_wb = 1'b1; rfe_wb = 1'b1; vector_wb = 5'b0; ext_irq = 1'b0; pc_wb = 32'h0000_0AA0;
        #1;
        chk("rfe_kill", kill_wb, 1);
        step();
        idle_inputs();
        chk("rfe_flush", flush, 1);
        step();
        chk("ret_flush", flush, 0);
        chk("ret_redirect", redirect, 1);
        chk("ret_rpc", redirect_pc, exp_rpc);
        step();
        chk("rfe_busy", busy, 0);
        chk("rfe_redirect", redirect, 0);
        chk("rfe_su", s_u, exp_su);
        chk("rfe_ie", ie, exp_ie);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        pc_wb = '0;
        step();
        valid_wb = 1'b1; vector_wb = 5'b11001;
        step();
        chk("rst_kill", kill_wb, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_epc", epc, 0);
        chk("rst_cause", cause, 0);
        chk("rst_ie", ie, 0);
        chk("rst_su", s_u, 0);
        chk("rst_busy", busy, 0);
        idle_inputs();
        rst_n = 1'b1;
        step();

        // undefined instruction
        run_exc(5'b11001, 0, 0, 32'h0000_2000, 1, 5'b11001, 32'h0000_2000, 32'h0000_01C8, 0);

        // saved status is otherwise unreachable from reset; preload it to enter user mode
        force dut.saved_sts = 2'b11;
        step();
        release dut.saved_sts;
        run_rfe(32'h0000_2000, 1, 1);

        // trap from user mode commits and returns past itself
        run_exc(5'b10011, 0, 0, 32'h0000_3000, 0, 5'b10011, 32'h0000_3004, 32'h0000_0198, 1);
        run_rfe(32'h0000_3004, 1, 1);

        // user-mode rfe becomes a privilege violation
        run_exc(5'b00000, 1, 0, 32'h0000_4000, 1, 5'b11000, 32'h0000_4000, 32'h0000_01C0, 1);

        // interrupt ignored while ie=0
        valid_wb = 1'b1; ext_irq = 1'b1; pc_wb = 32'h0000_5000;
        #1;
        chk("irq_ie0_kill", kill_wb, 0);
        step();
        idle_inputs();
        chk("irq_ie0_busy", busy, 0);

        run_rfe(32'h0000_4000, 1, 1);

        // interrupt ignored without a valid commit
        ext_irq = 1'b1;
        #1;
        chk("irq_nv_kill", kill_wb, 0);
        step();
        idle_inputs();
        chk("irq_nv_busy", busy, 0);

        run_exc(5'b00000, 0, 1, 32'h0000_5000, 1, 5'b00001, 32'h0000_5000, 32'h0000_0108, 1);
        run_rfe(32'h0000_5000, 1, 1);

        // explicit fetch-fault vector outranks the interrupt
        run_exc(5'b11010, 0, 1, 32'h0000_6000, 1, 5'b11010, 32'h0000_6000, 32'h0000_01D0, 1);

        // reset in SAVE abandons the sequence
        valid_wb = 1'b1; vector_wb = 5'b11001; pc_wb = 32'h0000_7000;
        step();
        idle_inputs();
        step();
        chk("save_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk("rsave_busy", busy, 0);
        chk("rsave_epc", epc, 0);
        chk("rsave_su", s_u, 0);
        chk("rsave_redirect", redirect, 0);
        chk("rsave_cause", cause, 0);
        rst_n = 1'b1;
        step();
        chk("rsave_redirect2", redirect, 0);
        chk("rsave_busy2", busy, 0);
        step();
        chk("rsave_redirect3", redirect, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0100, base address of the handler table.
REQ-002 SHALL have parameter VEC_STRIDE_LOG2, default 3, log2 of the bytes per handler slot.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 valid_wb  in  1  instruction at commit is valid.
REQ-006 vector_wb  in  5  vector accompanying the commit instruction; 5'b00000 = none.
REQ-007 pc_wb  in  32  PC of the commit instruction.
REQ-008 rfe_wb  in  1  commit instruction is rfe.
REQ-009 ext_irq  in  1  level-sensitive external interrupt request.
REQ-010 kill_wb  out  1  combinational; suppresses the architectural commit of the current instruction.
REQ-011 flush  out  1  pipeline flush pulse.
REQ-012 redirect  out  1  fetch redirect pulse.
REQ-013 redirect_pc  out  32  fetch target, valid while redirect=1.
REQ-014 s_u  out  1  current mode; 1=user, 0=supervisor.
REQ-015 ie  out  1  interrupt enable.
REQ-016 epc  out  32  saved return PC.
REQ-017 cause  out  5  vector of the last taken exception.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 Vector classes SHALL be: 11001 undefined instruction, 11000 privilege violation, 10xxx trap, >11001 fetch fault, 00001 external interrupt.
REQ-020 In IDLE with valid_wb=1, the accept priority SHALL be: vector_wb!=0, then rfe_wb, then ext_irq&&ie.
REQ-021 An rfe_wb with s_u=1 and vector_wb=0 SHALL be taken as vector 11000 and SHALL NOT execute as rfe.
REQ-022 Any accept SHALL assert kill_wb in the same cycle, except a trap (10xxx), whose instruction commits.
REQ-023 FSM states SHALL be IDLE, FLUSH, SAVE, JUMP and RET.
REQ-024 Exception path SHALL be IDLE->FLUSH->SAVE->JUMP->IDLE.
REQ-025 rfe path SHALL be IDLE->FLUSH->RET->IDLE.
REQ-026 Each non-IDLE state SHALL last exactly 1 cycle.
REQ-027 flush SHALL be 1 exactly in FLUSH.
REQ-028 Accept cycle N SHALL latch the vector and pc_wb into internal registers.
REQ-029 In SAVE, the following SHALL update at the end of the cycle: epc = pc (pc+4 for traps, 32-bit wrap); cause = vector; saved {s_u, ie} = current values; s_u = 0; ie = 0.
REQ-030 In JUMP (cycle N+3), redirect SHALL be 1 and redirect_pc SHALL be VEC_BASE + (vector << VEC_STRIDE_LOG2).
REQ-031 In RET (cycle N+2), redirect SHALL be 1, redirect_pc SHALL be epc, and s_u/ie SHALL be restored from the saved {s_u, ie} at the end of the cycle.
REQ-032 While busy=1, valid_wb, rfe_wb and ext_irq SHALL be ignored, and kill_wb SHALL be 0.
REQ-033 ext_irq SHALL NOT be taken when ie=0, nor when valid_wb=0.
REQ-034 Outside FLUSH, JUMP and RET, flush, redirect and redirect_pc SHALL be 0.

Reset
REQ-035 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, abandoning any sequence in progress.
REQ-036 Under reset, the following SHALL be 0: flush, redirect, redirect_pc, epc, cause, ie and the saved status.
REQ-037 Under reset, s_u SHALL be 0 (supervisor).
REQ-038 kill_wb SHALL be 0 while rst_n=0.

Structure
REQ-039 Vector constants (NODEF, PRIV, TRAP prefix, IRQ), FSM state encodings and VEC_BASE defaults SHALL live in shared package exc_pkg, also used by the ID-stage vector logic.
REQ-040 Accept-priority selection SHALL be one combinational sub-module, exc_prio; the FSM and registers SHALL stay in exception_ctrl.

Verification
REQ-041 Scenario: undefined instruction. valid_wb=1, vector_wb=11001, pc_wb=0x2000 at N -> kill_wb=1 at N; flush at N+1; epc=0x2000, cause=11001, s_u=0 after N+2; redirect at N+3 with redirect_pc=0x01C8.
REQ-042 Scenario: trap. vector_wb=10011, pc_wb=0x3000, user mode -> kill_wb=0; epc=0x3004; redirect_pc=0x0198; after rfe, s_u returns to 1.
REQ-043 Scenario: rfe. rfe_wb=1, s_u=0, epc=0x4000, saved {s_u,ie}={1,1} -> flush at N+1; redirect at N+2 to 0x4000; s_u=1, ie=1 afterwards.
REQ-044 Scenario: user-mode rfe. rfe_wb=1 with s_u=1 -> handled as cause 11000; redirect_pc=0x01C0; s_u unchanged until SAVE, then 0.
REQ-045 Scenario: ext_irq gating. ext_irq=1 with ie=0 -> no action. Set ie=1 via rfe, then ext_irq=1 with valid_wb=1, pc_wb=0x5000 -> cause=00001, epc=0x5000, redirect_pc=0x0108. Also assert vector_wb=11010 together with ext_irq -> cause=11010.
REQ-046 Scenario: reset during SAVE. rst_n=0 -> next cycle in IDLE with busy=0, epc=0, s_u=0, and no redirect issued.
